// File: rtl/apb_requester_pkg.sv
// apb_requester_pkg: shared state encoding, command/response records and default widths
// for the APB requester (package apb_pkg).
package apb_pkg;

    localparam int APB_PROT_W = 3;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                    write;
        logic [APB_ADDR_W-1:0]   addr;
        logic [APB_DATA_W-1:0]   wdata;
        logic [APB_DATA_W/8-1:0] strb;
        logic [APB_PROT_W-1:0]   prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_requester.sv
// apb_requester: APB4 requester running one SETUP/ACCESS transfer per accepted command.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_requester
    import apb_pkg::*;
#(
    parameter int  ADDR_W         = APB_ADDR_W,
    parameter int  DATA_W         = APB_DATA_W,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int STRB_W         = DATA_W / 8
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [STRB_W-1:0]     cmd_strb,
    input  logic [APB_PROT_W-1:0] cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     paddr,
    output logic [APB_PROT_W-1:0] pprot,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    output logic [STRB_W-1:0]     pstrb,
    input  logic                  pready,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pslverr
);

    if (TIMEOUT_CYCLES < 1 || (DATA_W != 8 && DATA_W != 16 && DATA_W != 32)) begin : g_bad_cfg
        $error("apb_requester: unsupported TIMEOUT_CYCLES or DATA_W");
    end

    apb_state_e              state_q, state_d;
    logic                    write_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic [APB_PROT_W-1:0]   prot_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    slverr_q;
    logic                    timeout_hit;
    logic                    access_done;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_q;
    logic             timeout_q;
    // The last permitted wait state is the one where the count already equals TIMEOUT_CYCLES-1.
    assign timeout_hit = state_q == ACCESS && !pready && wait_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign rsp_timeout = timeout_q;
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == SETUP) wait_q <= '0;
            else if (state_q == ACCESS && !pready) wait_q <= wait_q + 1'b1;
            if (access_done) timeout_q <= !pready;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign access_done = state_q == ACCESS && (pready || timeout_hit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = access_done ? RESP : ACCESS;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prot_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                prot_q  <= cmd_prot;
                wdata_q <= cmd_write ? cmd_wdata : '0;
                strb_q  <= cmd_write ? cmd_strb : '0;
            end
            // A timeout abort (pready low) reports an error with no data.
            if (access_done) begin
                rdata_q  <= (write_q || !pready) ? '0 : prdata;
                slverr_q <= pready ? pslverr : 1'b1;
            end
        end
    end

    assign cmd_ready  = state_q == IDLE;
    assign psel       = state_q == SETUP || state_q == ACCESS;
    assign penable    = state_q == ACCESS;
    assign rsp_valid  = state_q == RESP;
    assign rsp_rdata  = rdata_q;
    assign rsp_slverr = slverr_q;
    assign paddr      = addr_q;
    assign pprot      = prot_q;
    assign pwrite     = write_q;
    assign pwdata     = wdata_q;
    assign pstrb      = strb_q;

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 requester (master) for our APB completer environment; the bench drives this block against a completer DUT or model.
- Accepts one command on a valid/ready request channel and runs the APB SETUP/ACCESS sequence, honouring completer wait states.
- Returns read data and error status on a valid/ready response channel.
- One transfer in flight at a time.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of write/read data; must be 8, 16 or 32
TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort (used only with APB_TIMEOUT_EN); must be >= 1
STRB_W (localparam), DATA_W/8, strobe width

Ports:
pclk  in  1  clock
preset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  STRB_W  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_slverr  out  1  completer signalled error (or timeout)
rsp_timeout  out  1  transfer aborted by timeout (tied 0 without APB_TIMEOUT_EN)
paddr  out  ADDR_W  APB address
pprot  out  3  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  STRB_W  APB strobes
pready  in  1  completer ready
prdata  in  DATA_W  completer read data
pslverr  in  1  completer error

Behaviour:
- Interface: one clock, pclk. Reset preset_n is asynchronous and active-low.
- Reset: all outputs 0 except cmd_ready=1; state IDLE. Reset mid-transfer aborts immediately: psel/penable drop asynchronously and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register cmd_* fields -> SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0; always -> ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1.
  - On pready=1: capture prdata (reads only; writes give rsp_rdata=0) and pslverr -> RESP.
  - On pready=0: stay in ACCESS (wait state).
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - rsp_* held stable until rsp_ready; then -> IDLE.
  - rsp_ready sampled in the same cycle rsp_valid rises counts as a handshake.
- Bus signal stability:
  - paddr, pprot, pwrite, pwdata and pstrb are stable from SETUP through the final ACCESS cycle.
  - For reads, pwdata=0 and pstrb=0.
  - Outside SETUP/ACCESS, bus outputs hold their last values; psel/penable are 0.
- Timing: minimum latency from command accept to rsp_valid is 3 cycles (accept, SETUP, ACCESS with pready=1, then RESP). Each wait state adds 1 cycle.
- Throughput: cmd_ready=0 from SETUP until return to IDLE, so back-to-back commands are separated by at least 4 cycles.
- pslverr is sampled only when psel && penable && pready; ignored otherwise.
- pready in SETUP or IDLE is ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A wait counter, sized $clog2(TIMEOUT_CYCLES+1), clears on SETUP and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, go to RESP with rsp_slverr=1, rsp_timeout=1 and rsp_rdata=0.
  - pready=1 on that same cycle wins: normal completion, no timeout.
- Without the macro: no counter; rsp_timeout is tied 0; the block waits indefinitely in ACCESS.

Decomposition:
- Package apb_pkg:
  - enum apb_state_e {IDLE, SETUP, ACCESS, RESP}
  - typedef apb_cmd_t struct {write, addr, wdata, strb, prot}
  - typedef apb_rsp_t struct {rdata, slverr, timeout}
  - constants APB_PROT_W=3, default ADDR_W and DATA_W
- No sub-module needed. The timeout counter is small and stays inline under the ifdef.

Test Plan:
1. Write, zero wait states: cmd write addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, pready=1 in first ACCESS -> psel rises 1 cycle after accept, penable the next; pwdata=0xDEADBEEF throughout; rsp_valid 3 cycles after accept with slverr=0, rdata=0.
2. Read with 3 wait states: pready low 3 ACCESS cycles, prdata=0x1234_5678 on the 4th -> rsp_rdata=0x12345678; paddr stable over all 5 bus cycles; pstrb=0 throughout.
3. Error: write where the completer returns pready=1, pslverr=1 -> rsp_slverr=1; psel/penable low the following cycle.
4. Response backpressure: rsp_ready held low 5 cycles with cmd_valid held high -> rsp fields stable, cmd_ready=0, no new SETUP until the cycle after the rsp handshake.
5. Reset mid-ACCESS: assert preset_n=0 during a wait state -> psel, penable and rsp_valid go 0 immediately; cmd_ready=1 after release; next command runs normally.
6. (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4) pready held 0 -> rsp_slverr=1, rsp_timeout=1 after the 4th ACCESS cycle. Repeat with pready=1 exactly on the 4th cycle -> normal completion, rsp_timeout=0.
